// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversampling, start/data/stop sequencing,
// one-entry holding register with valid/ready handshake and error flags.
module uart_rx_ctrl #(
  parameter int CLK_FREQUENCY = 20000000,
  parameter int BAUD_RATE     = 9600,
  parameter int BAUD_DIVISION = CLK_FREQUENCY / (16 * BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       busy
);

  localparam int DW = (BAUD_DIVISION > 1) ? $clog2(BAUD_DIVISION) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIVISION - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state_q, state_d;

  logic          rx_meta, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    s_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          start_ok, bit_samp, stop_good, stop_bad;

  assign tick = (state_q != IDLE) && (div_cnt == DIV_LAST);
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    bit_samp  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tick && s_cnt == 4'd7) begin
          if (!rx_s) begin
            state_d  = DATA;
            start_ok = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && s_cnt == 4'd15) begin
          bit_samp = 1'b1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && s_cnt == 4'd15) begin
          if (rx_s) begin
            stop_good = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      s_cnt   <= '0;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      if (state_q == IDLE || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;

      if (state_q == IDLE) s_cnt <= '0;
      else if (tick) begin
        if (state_d != state_q || bit_samp) s_cnt <= '0;
        else s_cnt <= s_cnt + 4'd1;
      end

      if (start_ok) bit_idx <= '0;
      else if (bit_samp) bit_idx <= bit_idx + 3'd1;

      if (bit_samp) shift_q[bit_idx] <= rx_s;
    end
  end

  // A byte arriving while the held one is taken at the same edge replaces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (stop_good && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (stop_good && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl.
// Bench clocking gives two clocks per oversample tick, 32 clocks per bit.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       overrun_clr;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int         vcnt = 0;
  int         fcnt = 0;
  logic [7:0] last_data = 8'h00;

  uart_rx_ctrl #(
    .CLK_FREQUENCY(3200),
    .BAUD_RATE(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .overrun_clr(overrun_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt      <= vcnt + 1;
      last_data <= rx_data;
    end
    if (frame_err) fcnt <= fcnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clk(32);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(32);
    end
    rx = stop;
    wait_clk(32);
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    rx          = 1'b1;
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
    wait_clk(4);
    tests++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got %b exp 0000",
               {rx_valid, frame_err, overrun, busy});
    end
    tests++;
    if (rx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data got %h exp 00", rx_data);
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_basic;
    int v0, f0;
    v0 = vcnt;
    f0 = fcnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_clk(10);
    tests++;
    if (vcnt - v0 !== 1) begin
      fails++;
      $display("FAIL basic_valid_cycles got %0d exp 1", vcnt - v0);
    end
    tests++;
    if (last_data !== 8'hA5) begin
      fails++;
      $display("FAIL basic_data got %h exp a5", last_data);
    end
    tests++;
    if (fcnt - f0 !== 0 || overrun !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_flags got fe=%0d ovr=%b busy=%b exp 0 0 0",
               fcnt - f0, overrun, busy);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = vcnt;
    f0 = fcnt;
    rx = 1'b0;
    wait_clk(5);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy got %b exp 1", busy);
    end
    wait_clk(5);
    rx = 1'b1;
    wait_clk(40);
    tests++;
    if (vcnt - v0 !== 0 || fcnt - f0 !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_abort got v=%0d fe=%0d busy=%b exp 0 0 0",
               vcnt - v0, fcnt - f0, busy);
    end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h3C, 1'b0);
    wait_clk(100);
    tests++;
    if (fcnt - f0 !== 1) begin
      fails++;
      $display("FAIL ferr_pulse got %0d exp 1", fcnt - f0);
    end
    tests++;
    if (busy !== 1'b1 || vcnt - v0 !== 0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL ferr_break got busy=%b v=%0d ovr=%b exp 1 0 0",
               busy, vcnt - v0, overrun);
    end
    rx = 1'b1;
    wait_clk(5);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ferr_idle got %b exp 0", busy);
    end
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clk(5);
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      fails++;
      $display("FAIL ovr_hold got v=%b d=%h exp 1 11", rx_valid, rx_data);
    end
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_set got %b exp 1", overrun);
    end
    overrun_clr = 1'b1;
    wait_clk(1);
    overrun_clr = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clr got %b exp 0", overrun);
    end
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    tests++;
    if (rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovr_consume got %b exp 0", rx_valid);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(8'h55, 1'b1);
    wait_clk(5);
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      fails++;
      $display("FAIL b2b_first got v=%b d=%h exp 1 55", rx_valid, rx_data);
    end
    // Stop sample is taken at the 307th edge after the start bit is driven.
    fork
      send_frame(8'h66, 1'b1);
      begin
        wait_clk(306);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
      end
    join
    wait_clk(2);
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h66) begin
      fails++;
      $display("FAIL b2b_replace got v=%b d=%h exp 1 66", rx_valid, rx_data);
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL b2b_overrun got %b exp 0", overrun);
    end
    rx_ready = 1'b1;
    wait_clk(2);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int v0;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        wait_clk(170);
        rst_n = 1'b0;
        wait_clk(3);
        tests++;
        if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 ||
            rx_data !== 8'h00) begin
          fails++;
          $display("FAIL rst_mid got flags=%b d=%h exp 0000 00",
                   {rx_valid, frame_err, overrun, busy}, rx_data);
        end
        rst_n = 1'b1;
      end
    join
    wait_clk(20);
    tests++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_tail got busy=%b v=%b exp 0 0", busy, rx_valid);
    end
    v0 = vcnt;
    rx_ready = 1'b1;
    send_frame(8'h0F, 1'b1);
    wait_clk(10);
    tests++;
    if (vcnt - v0 !== 1 || last_data !== 8'h0F) begin
      fails++;
      $display("FAIL rst_resend got v=%0d d=%h exp 1 0f", vcnt - v0, last_data);
    end
    rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
